// File: rtl/rs_encoder_ctrl.sv
// Frame sequencer for an RS(N,K) encoder: loads K message symbols, then shifts out N-K parity symbols.
// Optional shortened-code support (msg_len port) is enabled by defining RS_SHORTEN_EN.
module rs_encoder_ctrl #(
  parameter int SYM_W = 8,
  parameter int N     = 255,
  parameter int K     = 239
) (
  input  logic             clk,
  input  logic             stop,
  input  logic             start,
  input  logic             in_valid,
  input  logic [SYM_W-1:0] in_data,
  output logic             in_ready,
  output logic [SYM_W-1:0] enc_mx,
  output logic             enc_clr,
  output logic             enc_load,
  output logic             enc_work,
  input  logic [SYM_W-1:0] par_data,
  output logic             out_valid,
  output logic [SYM_W-1:0] out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             busy,
  output logic [7:0]       counter
`ifdef RS_SHORTEN_EN
  ,
  input  logic [7:0]       msg_len
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CLR  = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;
  localparam logic [1:0] S_PAR  = 2'd3;

  localparam logic [7:0] K_L = 8'(K);
  localparam logic [7:0] P_L = 8'(N - K);

  logic [1:0]       state_q, state_d;
  logic             pend_q, pend_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic [SYM_W-1:0] data_q, data_d;
  logic [7:0]       len_w;
  logic             accept;

`ifdef RS_SHORTEN_EN
  logic [7:0] len_q, len_d;
  logic [7:0] len_clamped;

  // A zero length still carries one message symbol; lengths beyond K saturate.
  assign len_clamped = (msg_len == 8'd0) ? 8'd1 : ((msg_len > K_L) ? K_L : msg_len);
  assign len_w       = len_q;

  always_comb begin
    len_d = len_q;
    if (state_q == S_IDLE && start) len_d = len_clamped;
  end

  always_ff @(posedge clk or posedge stop) begin
    if (stop) len_q <= K_L;
    else      len_q <= len_d;
  end
`else
  assign len_w = K_L;
`endif

  assign accept   = in_valid && (state_q == S_LOAD);
  assign in_ready = (state_q == S_LOAD);
  assign enc_clr  = (state_q == S_CLR);
  assign enc_load = accept;
  assign enc_mx   = accept ? in_data : '0;
  assign enc_work = (state_q == S_PAR);
  assign busy     = (state_q != S_IDLE);
  assign counter  = cnt_q;

  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    data_d  = data_q;
    if (start && state_q != S_IDLE) pend_d = 1'b1;
    case (state_q)
      S_IDLE: if (start) state_d = S_CLR;
      S_CLR: begin
        cnt_d   = 8'd0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (accept) begin
          vld_d  = 1'b1;
          data_d = in_data;
          sop_d  = (cnt_q == 8'd0);
          if (cnt_q == len_w - 8'd1) begin
            cnt_d   = 8'd0;
            state_d = S_PAR;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: begin
        vld_d  = 1'b1;
        data_d = par_data;
        cnt_d  = cnt_q + 8'd1;
        if (cnt_q == P_L - 8'd1) begin
          eop_d   = 1'b1;
          // A start arriving on the final parity cycle still chains the next frame.
          state_d = (pend_q || start) ? S_CLR : S_IDLE;
        end
      end
    endcase
    if (state_d == S_CLR && state_q != S_CLR) pend_d = 1'b0;
  end

  always_ff @(posedge clk or posedge stop) begin
    if (stop) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      cnt_q   <= 8'd0;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_rs_encoder_ctrl.sv
// Directed bench for rs_encoder_ctrl with a scoreboard of expected codeword symbols.
// Includes the shortened-code scenario when RS_SHORTEN_EN is defined.
module tb_rs_encoder_ctrl;

  localparam int K  = 239;
  localparam int NP = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } exp_t;

  logic       clk;
  logic       stop;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] enc_mx;
  logic       enc_clr;
  logic       enc_load;
  logic       enc_work;
  logic [7:0] par_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;
  logic       busy;
  logic [7:0] counter;
`ifdef RS_SHORTEN_EN
  logic [7:0] msg_len;
`endif

  rs_encoder_ctrl #(.SYM_W(8), .N(255), .K(K)) dut (
    .clk(clk), .stop(stop), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .enc_mx(enc_mx), .enc_clr(enc_clr), .enc_load(enc_load), .enc_work(enc_work),
    .par_data(par_data),
    .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .busy(busy), .counter(counter)
`ifdef RS_SHORTEN_EN
    , .msg_len(msg_len)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Toy encoder core: parity index advances on each shift, restarts on clear.
  logic [7:0] pj;
  function automatic logic [7:0] par_fn(input logic [7:0] j);
    return 8'h5A ^ 8'(j * 8'd29);
  endfunction
  always @(posedge clk or posedge stop) begin
    if (stop)          pj <= 8'd0;
    else if (enc_clr)  pj <= 8'd0;
    else if (enc_work) pj <= pj + 8'd1;
  end
  assign par_data = par_fn(pj);

  exp_t q[$];
  int   exp_len[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   clr_cnt = 0;
  int   work_cnt = 0;
  int   pulse_cnt = 0;
  int   eop_cnt = 0;
  logic chain_exp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {in_ready, enc_mx, enc_clr, enc_load, enc_work, out_valid, out_data,
            out_sop, out_eop, busy, counter};
  endfunction

  task automatic monitor();
    exp_t e;
    logic acc;
    acc = in_valid && in_ready;
    chk("enc_load", 32'(enc_load), 32'(acc));
    chk("enc_mx", 32'(enc_mx), acc ? 32'(in_data) : 32'd0);
    chk("load_work_excl", 32'(enc_load && enc_work), 32'd0);
    if (enc_clr) clr_cnt++;
    if (enc_work) work_cnt++;
    if (out_valid) begin
      pulse_cnt++;
      chk("sop_eop_excl", 32'(out_sop && out_eop), 32'd0);
      chk("exp_avail", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_sop", 32'(out_sop), 32'(e.sop));
        chk("out_eop", 32'(out_eop), 32'(e.eop));
      end
      if (out_sop) begin
        chk("clr_per_frame", 32'(clr_cnt), 32'd1);
        clr_cnt = 0;
      end
      if (out_eop) begin
        chk("frame_len", 32'(pulse_cnt), (exp_len.size() != 0) ? 32'(exp_len.pop_front()) : 32'd0);
        chk("work_cycles", 32'(work_cnt), 32'(NP));
        chk("chain_clr", 32'(enc_clr), 32'(chain_exp));
        pulse_cnt = 0;
        work_cnt  = 0;
        eop_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input int mlen);
    exp_len.push_back(mlen + NP);
  endtask

  task automatic begin_frame(input int ml);
`ifdef RS_SHORTEN_EN
    msg_len = 8'(ml);
`else
    chk("frame_len_req", 32'(ml), 32'(K));
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drives symbols 1..len; optionally gaps every 3rd cycle, holds start for a symbol window,
  // or asserts stop while symbol abort_at is presented.
  task automatic send_msg(input int len, input bit gaps, input int abort_at,
                          input int hold_lo, input int hold_hi);
    int   sym = 1;
    int   cyc = 0;
    int   eops;
    logic acc;
    while (sym <= len && cyc < 2000) begin
      in_valid = gaps ? ((cyc % 3) != 2) : 1'b1;
      in_data  = 8'(sym);
      start    = (sym >= hold_lo) && (sym <= hold_hi);
      cyc++;
      @(negedge clk);
      monitor();
      if (sym == abort_at) begin
        eops = eop_cnt;
        #2;
        stop = 1'b1;
        #1;
        chk("abort_outputs_zero", outs_vec(), 32'd0);
        chk("abort_q_empty", 32'(q.size()), 32'd0);
        q.delete();
        exp_len.delete();
        clr_cnt = 0; work_cnt = 0; pulse_cnt = 0;
        in_valid = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        stop = 1'b0;
        repeat (20) tick();
        chk("abort_no_eop", 32'(eop_cnt), 32'(eops));
        chk("abort_idle", 32'(busy), 32'd0);
        return;
      end
      if (in_ready) chk("counter_load", 32'(counter), 32'(sym - 1));
      acc = in_valid && in_ready;
      if (acc) q.push_back('{data: 8'(sym), sop: (sym == 1), eop: 1'b0});
      @(posedge clk);
      #1;
      if (acc) sym++;
    end
    chk("msg_accepted", 32'(sym > len), 32'd1);
    in_valid = 1'b0;
    start    = 1'b0;
    for (int j = 0; j < NP; j++)
      q.push_back('{data: par_fn(8'(j)), sop: 1'b0, eop: (j == NP - 1)});
  endtask

  task automatic wait_eop(input int budget);
    int target;
    int c = 0;
    target = eop_cnt + 1;
    while (eop_cnt < target && c < budget) begin
      tick();
      c++;
    end
    chk("eop_seen", 32'(eop_cnt >= target), 32'd1);
  endtask

  initial begin
    stop = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
`ifdef RS_SHORTEN_EN
    msg_len = 8'(K);
`endif
    @(posedge clk);
    #1;
    chk("reset_outputs", outs_vec(), 32'd0);
    @(posedge clk);
    #1;
    stop = 1'b0;
    tick();
    chk("idle_outputs", outs_vec(), 32'd0);

    // T1: full frame, continuous input
    expect_frame(K);
    begin_frame(K);
    send_msg(K, 1'b0, 0, 0, 0);
    wait_eop(100);
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_counter_after", 32'(counter), 32'(NP));

    // T2: input gaps every 3rd cycle
    expect_frame(K);
    begin_frame(K);
    send_msg(K, 1'b1, 0, 0, 0);
    wait_eop(100);
    chk("t2_busy_after", 32'(busy), 32'd0);

    // T3: abort at accept 100, then a clean frame
    expect_frame(K);
    begin_frame(K);
    send_msg(K, 1'b0, 100, 0, 0);
    expect_frame(K);
    begin_frame(K);
    send_msg(K, 1'b0, 0, 0, 0);
    wait_eop(100);

    // T4: start during parity chains straight into the next frame
    expect_frame(K);
    expect_frame(K);
    begin_frame(K);
    send_msg(K, 1'b0, 0, 0, 0);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chain_exp = 1'b1;
    wait_eop(100);
    chain_exp = 1'b0;
    chk("t4_load_next", 32'(in_ready), 32'd1);
    send_msg(K, 1'b0, 0, 0, 0);
    wait_eop(100);

    // T5: start held during load yields exactly one follow-on frame
    expect_frame(K);
    expect_frame(K);
    begin_frame(K);
    send_msg(K, 1'b0, 0, 50, 60);
    chain_exp = 1'b1;
    wait_eop(100);
    chain_exp = 1'b0;
    send_msg(K, 1'b0, 0, 0, 0);
    wait_eop(100);
    repeat (5) tick();
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_q_empty", 32'(q.size()), 32'd0);

`ifdef RS_SHORTEN_EN
    // T6: shortened frames, including clamped lengths
    expect_frame(10);
    begin_frame(10);
    send_msg(10, 1'b0, 0, 0, 0);
    wait_eop(100);
    expect_frame(1);
    begin_frame(0);
    send_msg(1, 1'b0, 0, 0, 0);
    wait_eop(100);
    expect_frame(K);
    begin_frame(250);
    send_msg(K, 1'b0, 0, 0, 0);
    wait_eop(100);
    repeat (3) tick();
    chk("t6_idle", 32'(busy), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
